// File: rtl/rtype_pkg.sv
// Shared constants and types for the R-type sequencer: MIPS opcode/funct codes,
// ALU control codes, FSM state encoding and the decoder result record.
package rtype_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StWrite,
        StDone,
        StErr
    } state_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction handshake plus register-file/ALU control bus of the R-type sequencer.
// The slave modport is the sequencer; the master modport is the surrounding environment.
interface rtype_sequencer_if #(
    parameter int unsigned COUNT_W = 16
) ();

    logic [31:0]        Instruction;
    logic               InstrValid;
    logic               InstrReady;
    logic [4:0]         ReadRegister1;
    logic [4:0]         ReadRegister2;
    logic [4:0]         WriteRegister;
    logic [31:0]        WriteData;
    logic               RegWrite;
    logic [3:0]         ALUOperation;
    logic [31:0]        ALUResult;
    logic               Zero;
    logic               Done;
    logic               Error;
    logic [31:0]        ResultOut;
    logic               ZeroOut;
    logic [COUNT_W-1:0] RetiredCount;

    modport slave (
        input  Instruction, InstrValid, ALUResult, Zero,
        output InstrReady, ReadRegister1, ReadRegister2, WriteRegister, WriteData,
               RegWrite, ALUOperation, Done, Error, ResultOut, ZeroOut, RetiredCount
    );

    modport master (
        output Instruction, InstrValid, ALUResult, Zero,
        input  InstrReady, ReadRegister1, ReadRegister2, WriteRegister, WriteData,
               RegWrite, ALUOperation, Done, Error, ResultOut, ZeroOut, RetiredCount
    );

endinterface

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: register fields, ALU control code and an illegal flag.
// Shamt is not used by any supported operation.
module rtype_decoder
    import rtype_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        dec.rs      = instr[25:21];
        dec.rt      = instr[20:16];
        dec.rd      = instr[15:11];
        dec.alu_op  = ALU_AND;
        dec.illegal = 1'b0;
        case (instr[5:0])
            FUNCT_ADD, FUNCT_ADDU: dec.alu_op = ALU_ADD;
            FUNCT_SUB, FUNCT_SUBU: dec.alu_op = ALU_SUB;
            FUNCT_AND:             dec.alu_op = ALU_AND;
            FUNCT_OR:              dec.alu_op = ALU_OR;
            FUNCT_NOR:             dec.alu_op = ALU_NOR;
            FUNCT_SLT:             dec.alu_op = ALU_SLT;
            default:               dec.illegal = 1'b1;
        endcase
        if (instr[31:26] != OP_RTYPE) begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle controller running one R-type instruction at a time on an external
// register file and ALU: accept, read, execute, write back, then report Done or Error.
module rtype_sequencer
    import rtype_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rtype_sequencer_if.slave bus
);

    state_e             state_q, state_d;
    decode_t            dec;
    logic               accept;
    logic [4:0]         rs_q, rt_q, rd_q;
    logic [3:0]         alu_op_q;
    logic [31:0]        result_q;
    logic               zero_q;
    logic [COUNT_W-1:0] count_q;

    rtype_decoder u_decoder (
        .instr (bus.Instruction),
        .dec   (dec)
    );

    assign accept = (state_q == StIdle) && bus.InstrValid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.InstrValid) state_d = dec.illegal ? StErr : StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs_q     <= dec.rs;
                rt_q     <= dec.rt;
                rd_q     <= dec.rd;
                alu_op_q <= dec.alu_op;
            end
            if (state_q == StExec) begin
                result_q <= bus.ALUResult;
                zero_q   <= bus.Zero;
            end
            if (state_q == StWrite) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Strobes decode straight from the state flop, so reset clears them asynchronously.
    assign bus.InstrReady    = (state_q == StIdle);
    assign bus.RegWrite      = (state_q == StWrite) && (rd_q != 5'd0);
    assign bus.Done          = (state_q == StDone);
    assign bus.Error         = (state_q == StErr);
    assign bus.ReadRegister1 = rs_q;
    assign bus.ReadRegister2 = rt_q;
    assign bus.WriteRegister = rd_q;
    assign bus.ALUOperation  = alu_op_q;
    assign bus.WriteData     = result_q;
    assign bus.ResultOut     = result_q;
    assign bus.ZeroOut       = zero_q;
    assign bus.RetiredCount  = count_q;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Self-checking bench: behavioural regfile/ALU environment, table of R-type vectors,
// scoreboard queue checked by a negedge monitor, plus back-to-back and mid-op reset.
module tb_rtype_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtype_sequencer_if #(.COUNT_W(16)) bus ();

    rtype_sequencer #(.COUNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment: naive register file (no $zero guard) and ALU.
    logic [31:0] rf [32] = '{1: 32'd10, 2: 32'd20, default: 32'd0};
    logic [31:0] op_a, op_b;
    assign op_a = rf[bus.ReadRegister1];
    assign op_b = rf[bus.ReadRegister2];

    always_comb begin
        case (bus.ALUOperation)
            4'b0000: bus.ALUResult = op_a & op_b;
            4'b0001: bus.ALUResult = op_a | op_b;
            4'b0010: bus.ALUResult = op_a + op_b;
            4'b0110: bus.ALUResult = op_a - op_b;
            4'b0111: bus.ALUResult = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b1100: bus.ALUResult = ~(op_a | op_b);
            default: bus.ALUResult = 32'hDEAD_BEEF;
        endcase
    end
    assign bus.Zero = (bus.ALUResult == 32'd0);

    always @(posedge clk) begin
        if (bus.RegWrite) rf[bus.WriteRegister] <= bus.WriteData;
    end

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
        logic [3:0]  alu;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          ncyc = 0;
    int          ready_due = 0;
    int          prev_acc = 0;
    bit          have_prev = 1'b0;
    bit          saw_wr = 1'b0;
    logic [15:0] exp_retired = 16'd0;
    logic [31:0] last_result = 32'd0;
    vec_t        exp_q[$];
    int          acc_q[$];
    vec_t        tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, ncyc);
    endtask

    // Monitor: samples on the falling edge; cycle E+k is the k-th negedge after accept E.
    always @(negedge clk) begin : monitor
        vec_t cur;
        int   d;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            saw_wr      = 1'b0;
            ready_due   = 0;
            exp_retired = 16'd0;
            last_result = 32'd0;
        end else begin
            ncyc++;
            if (ready_due != 0 && ncyc == ready_due) begin
                chk("ready_return", 32'(bus.InstrReady), 32'd1);
                chk("retired_count", 32'(bus.RetiredCount), 32'(exp_retired));
                ready_due = 0;
            end
            if (exp_q.size() == 0) begin
                if (bus.RegWrite) flag("spurious_regwrite");
                if (bus.Done)     flag("spurious_done");
                if (bus.Error)    flag("spurious_error");
            end else begin
                cur = exp_q[0];
                d   = ncyc - acc_q[0];
                chk("ready_busy", 32'(bus.InstrReady), 32'd0);
                if (bus.RegWrite) begin
                    chk("regwrite_allowed", 32'(cur.wr), 32'd1);
                    chk("regwrite_cycle", 32'(d), 32'd3);
                    chk("write_register", 32'(bus.WriteRegister), 32'(cur.rd));
                    chk("write_data", bus.WriteData, cur.data);
                    saw_wr = 1'b1;
                end
                if (bus.Done || bus.Error || d >= 5) begin
                    if (cur.err) begin
                        chk("error_cycle", 32'(d), 32'd1);
                        chk("error_pulse", 32'(bus.Error), 32'd1);
                        chk("no_done_on_error", 32'(bus.Done), 32'd0);
                        chk("result_kept", bus.ResultOut, last_result);
                    end else begin
                        chk("done_cycle", 32'(d), 32'd4);
                        chk("done_pulse", 32'(bus.Done), 32'd1);
                        chk("no_error_on_legal", 32'(bus.Error), 32'd0);
                        chk("result_out", bus.ResultOut, cur.data);
                        chk("zero_out", 32'(bus.ZeroOut), 32'(cur.zero));
                        chk("alu_operation", 32'(bus.ALUOperation), 32'(cur.alu));
                        exp_retired = exp_retired + 16'd1;
                        last_result = cur.data;
                    end
                    chk("wrote_back", 32'(saw_wr), 32'(cur.wr));
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    saw_wr    = 1'b0;
                    ready_due = ncyc + 1;
                end
            end
        end
    end

    // Presents v from posedge+1 until it is accepted; leaves InstrValid high.
    task automatic send(input vec_t v, input bit b2b);
        bit r = 1'b0;
        int n = 0;
        bus.Instruction = v.instr;
        bus.InstrValid  = 1'b1;
        while (!r && n < 20) begin
            @(negedge clk);
            r = bus.InstrReady;
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) begin
            flag("accept_timeout");
        end else begin
            if (b2b && have_prev) chk("b2b_gap", 32'(ncyc - prev_acc), 32'd5);
            exp_q.push_back(v);
            acc_q.push_back(ncyc);
            prev_acc  = ncyc;
            have_prev = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || ready_due != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || ready_due != 0) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          instr         err   wr    rd     data           zero  alu
        tbl[0]  = '{32'h00221820, 1'b0, 1'b1, 5'd3,  32'd30,        1'b0, 4'b0010};
        tbl[1]  = '{32'h00222022, 1'b0, 1'b1, 5'd4,  32'hFFFFFFF6,  1'b0, 4'b0110};
        tbl[2]  = '{32'h00212822, 1'b0, 1'b1, 5'd5,  32'd0,         1'b1, 4'b0110};
        tbl[3]  = '{32'h00220020, 1'b0, 1'b0, 5'd0,  32'd30,        1'b0, 4'b0010};
        tbl[4]  = '{32'h8C220000, 1'b1, 1'b0, 5'd0,  32'd0,         1'b0, 4'b0000};
        tbl[5]  = '{32'h00223024, 1'b0, 1'b1, 5'd6,  32'd0,         1'b1, 4'b0000};
        tbl[6]  = '{32'h00223825, 1'b0, 1'b1, 5'd7,  32'h0000001E,  1'b0, 4'b0001};
        tbl[7]  = '{32'h00224027, 1'b0, 1'b1, 5'd8,  32'hFFFFFFE1,  1'b0, 4'b1100};
        tbl[8]  = '{32'h0022482A, 1'b0, 1'b1, 5'd9,  32'd1,         1'b0, 4'b0111};
        tbl[9]  = '{32'h0041502A, 1'b0, 1'b1, 5'd10, 32'd0,         1'b1, 4'b0111};
        tbl[10] = '{32'h00011080, 1'b1, 1'b0, 5'd0,  32'd0,         1'b0, 4'b0000};
        tbl[11] = '{32'h00625821, 1'b0, 1'b1, 5'd11, 32'h00000032,  1'b0, 4'b0010};
        tbl[12] = '{32'h03E00008, 1'b1, 1'b0, 5'd0,  32'd0,         1'b0, 4'b0000};
        tbl[13] = '{32'h00246023, 1'b0, 1'b1, 5'd12, 32'h00000014,  1'b0, 4'b0110};
        tbl[14] = '{32'h00226960, 1'b0, 1'b1, 5'd13, 32'd30,        1'b0, 4'b0010};
        tbl[15] = '{32'h04221820, 1'b1, 1'b0, 5'd0,  32'd0,         1'b0, 4'b0000};

        bus.Instruction = 32'h00221820;
        bus.InstrValid  = 1'b1;
        #12;
        chk("rst_ready", 32'(bus.InstrReady), 32'd1);
        chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_error", 32'(bus.Error), 32'd0);
        chk("rst_addr", 32'({bus.ReadRegister1, bus.ReadRegister2, bus.WriteRegister}), 32'd0);
        chk("rst_aluop", 32'(bus.ALUOperation), 32'd0);
        chk("rst_result", bus.ResultOut, 32'd0);
        chk("rst_wdata", bus.WriteData, 32'd0);
        chk("rst_zero", 32'(bus.ZeroOut), 32'd0);
        chk("rst_retired", 32'(bus.RetiredCount), 32'd0);
        bus.InstrValid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            send(tbl[i], 1'b0);
            bus.InstrValid = 1'b0;
            wait_idle();
        end

        // InstrValid held high; changing Instruction while busy must be ignored.
        have_prev = 1'b0;
        send(tbl[0], 1'b1);
        send(tbl[1], 1'b1);
        send(tbl[2], 1'b1);
        send(tbl[6], 1'b1);
        bus.InstrValid = 1'b0;
        wait_idle();

        // Reset while in EXEC of add $14,$1,$2: nothing may be written or retired.
        send('{32'h00227020, 1'b0, 1'b1, 5'd14, 32'd30, 1'b0, 4'b0010}, 1'b0);
        bus.InstrValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("midrst_ready", 32'(bus.InstrReady), 32'd1);
        chk("midrst_retired", 32'(bus.RetiredCount), 32'd0);
        chk("midrst_result", bus.ResultOut, 32'd0);
        chk("midrst_aluop", 32'(bus.ALUOperation), 32'd0);
        chk("midrst_wreg", 32'(bus.WriteRegister), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_ready", 32'(bus.InstrReady), 32'd1);
        chk("post_rst_no_write", rf[14], 32'd0);
        @(posedge clk);
        #1;
        send(tbl[0], 1'b0);
        bus.InstrValid = 1'b0;
        wait_idle();

        chk("r0_untouched", rf[0], 32'd0);
        chk("r3_value", rf[3], 32'd30);
        chk("r4_value", rf[4], 32'hFFFFFFF6);
        chk("r12_value", rf[12], 32'h00000014);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
